control_sequencer: RTL

Hardwired Moore control unit that drives the datapath's register-transfer strobes, replacing hand-sequenced T-state stimulus. It fetches an instruction (T0-T2), decodes IR[31:27], runs the execute micro-steps (T3-T7), and returns to T0. It covers the subset ld, ldi, st, R-type ALU, immediate ALU, nop and halt. Datapath strobes this block does not produce (HIin, LOin, Yout, Zhighout, HIout, LOout, Inportin/out, Outportin/out, CONin, MARout) are tied 0 at the top level.

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/control_sequencer_instr_class_decode.sv | 47 ++++
 rtl/control_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode values, ALU select codes and state encodings for the
// hardwired control sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU selects used when an instruction borrows a register-form operation
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b01001;
  localparam logic [4:0] ALU_OR  = 5'b01010;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

endpackage

// File: rtl/control_sequencer_instr_class_decode.sv
// Classifies the instruction opcode field and picks the ALU operation the
// execute step should request.
module instr_class_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] op,
  output logic            is_rtype,
  output logic            is_imm,
  output logic            is_ld,
  output logic            is_ldi,
  output logic            is_st,
  output logic            is_nop,
  output logic            is_halt,
  output logic [OP_W-1:0] alu_op
);

  always_comb begin
    is_rtype = 1'b0;
    is_imm   = 1'b0;
    is_ld    = 1'b0;
    is_ldi   = 1'b0;
    is_st    = 1'b0;
    is_nop   = 1'b0;
    is_halt  = 1'b0;
    alu_op   = '0;
    case (op)
      OP_LD:   begin is_ld  = 1'b1; alu_op = ALU_ADD; end
      OP_LDI:  begin is_ldi = 1'b1; alu_op = ALU_ADD; end
      OP_ST:   begin is_st  = 1'b1; alu_op = ALU_ADD; end
      OP_ADDI: begin is_imm = 1'b1; alu_op = ALU_ADD; end
      OP_ANDI: begin is_imm = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin is_imm = 1'b1; alu_op = ALU_OR;  end
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: begin
        // register-form ops pass their own code straight to the ALU
        if (op >= OP_ADD && op <= OP_OR) begin
          is_rtype = 1'b1;
          alu_op   = op;
        end
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: fetch T0-T2, decode, execute T3-T7, with halt and
// stop handling at instruction boundaries.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] IR,
  input  logic              Stop,
  output logic              Run,
  output logic [3:0]        present_state,
  output logic              Read,
  output logic              Write,
  output logic              IncPC,
  output logic [OP_W-1:0]   opcode,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic              BAout,
  output logic              Yin,
  output logic              Zin,
  output logic              PCin,
  output logic              IRin,
  output logic              MARin,
  output logic              MDRin,
  output logic              Zlowout,
  output logic              PCout,
  output logic              MDRout,
  output logic              Cout
);

  state_t state, state_next;
  logic is_rtype, is_imm, is_ld, is_ldi, is_st, is_nop, is_halt;
  logic [OP_W-1:0] alu_op;
  logic exec, mem_class;
  logic unused_ir;

  assign unused_ir = ^{IR[DATA_W-OP_W-1:0], is_nop};

  instr_class_decode #(.OP_W(OP_W)) u_decode (
    .op       (IR[DATA_W-1 -: OP_W]),
    .is_rtype (is_rtype),
    .is_imm   (is_imm),
    .is_ld    (is_ld),
    .is_ldi   (is_ldi),
    .is_st    (is_st),
    .is_nop   (is_nop),
    .is_halt  (is_halt),
    .alu_op   (alu_op)
  );

  assign exec      = is_rtype | is_imm | is_ldi | is_ld | is_st;
  assign mem_class = is_ld | is_st;

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state <= S_RESET;
    else       state <= state_next;
  end

  // Stop is only looked at when an instruction retires
  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2: begin
        if (is_halt)   state_next = S_HALT;
        else if (exec) state_next = S_T3;
        else           state_next = Stop ? S_HALT : S_T0;
      end
      S_T3:    state_next = S_T4;
      S_T4:    state_next = S_T5;
      S_T5:    state_next = mem_class ? S_T6 : (Stop ? S_HALT : S_T0);
      S_T6:    state_next = S_T7;
      S_T7:    state_next = Stop ? S_HALT : S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    Read = 1'b0; Write = 1'b0; IncPC = 1'b0; opcode = '0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Yin = 1'b0; Zin = 1'b0; PCin = 1'b0; IRin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; Zlowout = 1'b0; PCout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
      S_T3: begin
        // ALU forms read Rb; address forms use base-address so R0 means 0
        if (exec) begin Grb = 1'b1; Yin = 1'b1; end
        if (is_rtype | is_imm)              Rout  = 1'b1;
        else if (is_ldi | is_ld | is_st)    BAout = 1'b1;
      end
      S_T4: begin
        if (is_rtype) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = alu_op;
        end else if (exec) begin
          Cout = 1'b1; Zin = 1'b1; opcode = alu_op;
        end
      end
      S_T5: begin
        if (is_rtype | is_imm | is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (mem_class) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld)      begin Read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        if (is_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end

  assign present_state = state;
  assign Run = (state != S_RESET) && (state != S_HALT);

endmodule
